// File: rtl/sisc_fetch.sv
// SISC fetch stage: PC/IR owner, imem handshake (2-cycle min req-to-done, waits on imem_ack), branch resolve.
// `define FETCH_TIMEOUT_EN bounds each fetch to MAX_WAIT cycles, then parks in ERR with a HLT in ir.
module sisc_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               fetch_req,
  input  logic               pc_write,
  input  logic [1:0]         br_type,
  input  logic               br_neg,
  input  logic [3:0]         br_mask,
  input  logic [3:0]         stat,
  input  logic [ADDR_W-1:0]  br_target,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               fetch_done,
  output logic               fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t              state;
  logic                taken;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   pc_nxt;
  logic [ADDR_W-1:0]   pc_sel;

  assign opcode = ir[INSTR_W-1 -: 4];
  assign mm     = ir[INSTR_W-5 -: 4];

  // br_target is already ADDR_W wide, so the relative add is the sign-extended, wrapping sum.
  always_comb begin
    taken  = ((stat & br_mask) != 4'd0) ^ br_neg;
    pc_inc = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    pc_nxt = pc_inc;
    case (br_type)
      2'b01:   pc_nxt = taken ? br_target : pc_inc;
      2'b10:   pc_nxt = taken ? (pc_inc + br_target) : pc_inc;
      default: pc_nxt = pc_inc;
    endcase
    pc_sel = pc_write ? pc_nxt : pc;
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int                 CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [INSTR_W-1:0] HLT_INSTR = {4'hF, {(INSTR_W-4){1'b0}}};
  logic [CNT_W-1:0] wait_cnt;
`else
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      ir         <= '0;
      imem_addr  <= '0;
      imem_rd    <= 1'b0;
      busy       <= 1'b0;
      fetch_done <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_err  <= 1'b0;
      wait_cnt   <= '0;
`endif
    end else begin
      fetch_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pc_write) pc <= pc_nxt;
          // The fetch address sees a PC update committed on the same edge.
          if (fetch_req) begin
            state     <= S_WAIT;
            imem_addr <= pc_sel;
            imem_rd   <= 1'b1;
            busy      <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            state      <= S_IDLE;
            ir         <= imem_data;
            fetch_done <= 1'b1;
            imem_rd    <= 1'b0;
            busy       <= 1'b0;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            state      <= S_ERR;
            ir         <= HLT_INSTR;
            fetch_done <= 1'b1;
            fetch_err  <= 1'b1;
            imem_rd    <= 1'b0;
            busy       <= 1'b0;
          end else begin
            wait_cnt   <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        default: begin
          // ERR is terminal until reset.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sisc_fetch.sv
// Directed bench for sisc_fetch: reset state, fetch handshake, branch resolution, WAIT-state blocking, timeout.
module tb_sisc_fetch;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        fetch_req, pc_write, br_neg, imem_ack;
  logic [1:0]  br_type;
  logic [3:0]  br_mask, stat;
  logic [15:0] br_target;
  logic [31:0] imem_data;
  logic [15:0] imem_addr, pc;
  logic        imem_rd, busy, fetch_done, fetch_err;
  logic [31:0] ir;
  logic [3:0]  opcode, mm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sisc_fetch dut (
    .clk(clk), .rst_f(rst_f), .fetch_req(fetch_req), .pc_write(pc_write),
    .br_type(br_type), .br_neg(br_neg), .br_mask(br_mask), .stat(stat),
    .br_target(br_target), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_ack(imem_ack), .imem_data(imem_data), .ir(ir), .opcode(opcode),
    .mm(mm), .pc(pc), .busy(busy), .fetch_done(fetch_done), .fetch_err(fetch_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic branch(input logic [1:0] t, input logic n, input logic [3:0] m,
                        input logic [3:0] s, input logic [15:0] tgt);
    br_type = t; br_neg = n; br_mask = m; stat = s; br_target = tgt;
    pc_write = 1'b1;
    tick();
    pc_write = 1'b0;
  endtask

  task automatic do_reset();
    rst_f = 1'b1;
    tick();
    rst_f = 1'b0;
    tick();
  endtask

  initial begin
    int done_cnt;
    int n;
    rst_f = 1'b1; fetch_req = 0; pc_write = 0; br_neg = 0; imem_ack = 0;
    br_type = 0; br_mask = 0; stat = 0; br_target = 0; imem_data = 0;
    tick();
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_imem_rd", imem_rd, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_fetch_done", fetch_done, 0);
    check("rst_fetch_err", fetch_err, 0);
    check("rst_busy", busy, 0);
    rst_f = 1'b0;
    tick();

    // Basic fetch, ack one cycle after the request is taken.
    fetch_req = 1; tick(); fetch_req = 0;
    check("f1_busy", busy, 1);
    check("f1_rd", imem_rd, 1);
    check("f1_addr", imem_addr, 16'h0000);
    check("f1_done_early", fetch_done, 0);
    imem_ack = 1; imem_data = 32'h1800_0005; tick(); imem_ack = 0;
    check("f1_done", fetch_done, 1);
    check("f1_ir", ir, 32'h1800_0005);
    check("f1_opcode", opcode, 4'h1);
    check("f1_mm", mm, 4'h8);
    check("f1_pc", pc, 16'h0000);
    check("f1_rd_drop", imem_rd, 0);
    check("f1_busy_drop", busy, 0);
    tick();
    check("f1_done_pulse", fetch_done, 0);

    // Ack outside WAIT must not touch ir.
    imem_ack = 1; imem_data = 32'hDEAD_BEEF; tick(); imem_ack = 0;
    check("stray_ack_ir", ir, 32'h1800_0005);
    check("stray_ack_done", fetch_done, 0);

    // PC update paths.
    branch(2'b01, 0, 4'b0001, 4'b0001, 16'hFFFF); check("bra_ffff", pc, 16'hFFFF);
    branch(2'b00, 0, 4'b0000, 4'b0000, 16'h1234); check("seq_wrap", pc, 16'h0000);
    branch(2'b11, 0, 4'b1111, 4'b1111, 16'h1234); check("rsvd_seq", pc, 16'h0001);
    branch(2'b01, 0, 4'b0100, 4'b0110, 16'h0040); check("bra_taken", pc, 16'h0040);
    branch(2'b01, 0, 4'b0100, 4'b0010, 16'h0080); check("bra_not", pc, 16'h0041);
    branch(2'b01, 0, 4'b0001, 4'b0001, 16'h0010); check("bra_0010", pc, 16'h0010);
    branch(2'b10, 1, 4'b0001, 4'b0000, 16'hFFFC); check("bnr_back", pc, 16'h000D);
    branch(2'b10, 0, 4'b0001, 4'b0000, 16'h0005); check("brr_not", pc, 16'h000E);
    branch(2'b01, 1, 4'b0001, 4'b0001, 16'h0200); check("bne_not", pc, 16'h000F);
    branch(2'b10, 0, 4'b1000, 4'b1000, 16'h0010); check("brr_fwd", pc, 16'h0020);

    // Simultaneous pc_write and fetch_req: fetch uses the new PC.
    br_type = 2'b01; br_neg = 0; br_mask = 4'b0001; stat = 4'b0001; br_target = 16'h0100;
    pc_write = 1; fetch_req = 1; tick(); pc_write = 0; fetch_req = 0;
    check("sim_pc", pc, 16'h0100);
    check("sim_addr", imem_addr, 16'h0100);
    check("sim_busy", busy, 1);

    // Ack after 5 WAIT cycles while pc_write/fetch_req are hammered.
    done_cnt = 0;
    br_type = 2'b00;
    for (int i = 0; i < 4; i++) begin
      pc_write = 1; fetch_req = 1; tick();
      if (fetch_done) done_cnt++;
      check("wait_pc", pc, 16'h0100);
      check("wait_addr", imem_addr, 16'h0100);
    end
    pc_write = 0; fetch_req = 0;
    imem_ack = 1; imem_data = 32'h2A00_0007; tick(); imem_ack = 0;
    if (fetch_done) done_cnt++;
    check("w5_ir", ir, 32'h2A00_0007);
    check("w5_opcode", opcode, 4'h2);
    check("w5_mm", mm, 4'hA);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (fetch_done) done_cnt++;
    end
    check("w5_done_count", done_cnt, 1);
    check("w5_pc", pc, 16'h0100);

`ifdef FETCH_TIMEOUT_EN
    // Ack on the last allowed cycle wins over the timeout.
    fetch_req = 1; tick(); fetch_req = 0;
    repeat (14) tick();
    imem_ack = 1; imem_data = 32'h3300_0000; tick(); imem_ack = 0;
    check("ackwin_done", fetch_done, 1);
    check("ackwin_ir", ir, 32'h3300_0000);
    check("ackwin_err", fetch_err, 0);
    tick();

    // No ack: timeout after 15 WAIT cycles.
    fetch_req = 1; tick(); fetch_req = 0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (fetch_done) begin n = i; break; end
    end
    check("to_cycles", n, 15);
    check("to_err", fetch_err, 1);
    check("to_ir", ir, 32'hF000_0000);
    check("to_opcode", opcode, 4'hF);
    check("to_rd", imem_rd, 0);
    check("to_busy", busy, 0);
    fetch_req = 1; tick(); fetch_req = 0;
    check("err_ignore_busy", busy, 0);
    check("err_ignore_rd", imem_rd, 0);
    tick();
    check("err_no_done", fetch_done, 0);
    check("err_sticky", fetch_err, 1);
    do_reset();
    check("err_cleared", fetch_err, 0);
    check("err_ir_cleared", ir, 0);
`else
    // Without the timeout, WAIT persists and the error flag stays low.
    fetch_req = 1; tick(); fetch_req = 0;
    repeat (20) tick();
    check("nto_busy", busy, 1);
    check("nto_err", fetch_err, 0);
    check("nto_done", fetch_done, 0);
    imem_ack = 1; imem_data = 32'h4500_0001; tick(); imem_ack = 0;
    check("nto_ack_done", fetch_done, 1);
    check("nto_ack_ir", ir, 32'h4500_0001);
    do_reset();
    check("rst2_pc", pc, 0);
`endif

    // Reset mid-fetch returns everything to idle.
    fetch_req = 1; tick(); fetch_req = 0;
    check("mid_busy", busy, 1);
    rst_f = 1; #1;
    check("mid_rst_rd", imem_rd, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_addr", imem_addr, 0);
    tick(); rst_f = 0; tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
